// File: rtl/hs_data_sync_ctrl.sv
// Destination-side controller for a 4-phase REQ/ACK multi-bit CDC transfer.
// Optional capture parity check is enabled by defining HS_DATA_PARITY_EN.
module hs_data_sync_ctrl #(
    parameter int unsigned BUS_WIDTH   = 8,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 D_CLK,
    input  logic                 D_RST,
    input  logic                 SYNC_REQ,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 ERR_CLR,
`ifdef HS_DATA_PARITY_EN
    input  logic                 DATA_PAR,
    output logic                 PAR_ERR,
`endif
    output logic                 ACK,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE,
    output logic                 BUSY,
    output logic                 TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CAPT   = 2'd1,
        ST_ACK_HI = 2'd2,
        ST_ABORT  = 2'd3
    } state_t;

    localparam logic             TO_EN    = (TIMEOUT_CYC != 32'd0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 32'd0) ? 32'd0 : (TIMEOUT_CYC - 32'd1));
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t               state_q, state_d;
    logic                 ack_q, ack_d;
    logic [BUS_WIDTH-1:0] bus_q, bus_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 cap_ok;
`ifdef HS_DATA_PARITY_EN
    logic                 par_q, par_d;
`endif

    // A capture is accepted unless the optional parity check rejects it.
`ifdef HS_DATA_PARITY_EN
    assign cap_ok = ((^UNSYNC_BUS) == DATA_PAR);
`else
    assign cap_ok = 1'b1;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        bus_d   = bus_q;
        en_d    = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef HS_DATA_PARITY_EN
        par_d   = 1'b0;
`endif

        if (ERR_CLR) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                ack_d = 1'b0;
                if (SYNC_REQ) begin
                    state_d = ST_CAPT;
                end
            end
            // One settle cycle for the bus; REQ is deliberately ignored here.
            ST_CAPT: begin
                ack_d   = 1'b1;
                cnt_d   = '0;
                state_d = ST_ACK_HI;
                if (cap_ok) begin
                    bus_d = UNSYNC_BUS;
                    en_d  = 1'b1;
                end
`ifdef HS_DATA_PARITY_EN
                else begin
                    par_d = 1'b1;
                end
`endif
            end
            ST_ACK_HI: begin
                if (!SYNC_REQ) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_ABORT;
                end else if (TO_EN && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Hold off until the stale REQ has been withdrawn.
            ST_ABORT: begin
                ack_d = 1'b0;
                if (!SYNC_REQ) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge D_CLK) begin
        if (D_RST) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            bus_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef HS_DATA_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef HS_DATA_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign ACK          = ack_q;
    assign SYNC_BUS     = bus_q;
    assign ENABLE_PULSE = en_q;
    assign BUSY         = busy_q;
    assign TIMEOUT_ERR  = err_q;
`ifdef HS_DATA_PARITY_EN
    assign PAR_ERR      = par_q;
`endif

endmodule

// File: tb/tb_hs_data_sync_ctrl.sv
// Self-checking bench for hs_data_sync_ctrl: vector table of handshakes plus
// hand-written reset, glitch, timeout and abort sequences; captures scoreboarded.
module tb_hs_data_sync_ctrl;

    localparam int TO = 4;

    logic       D_CLK = 1'b0;
    logic       D_RST;
    logic       SYNC_REQ;
    logic [7:0] UNSYNC_BUS;
    logic       ERR_CLR;
    logic       ACK;
    logic [7:0] SYNC_BUS;
    logic       ENABLE_PULSE;
    logic       BUSY;
    logic       TIMEOUT_ERR;
`ifdef HS_DATA_PARITY_EN
    logic       DATA_PAR;
    logic       PAR_ERR;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        int         hold;
        logic       exp_to;
    } vec_t;

    vec_t vecs[7];

    hs_data_sync_ctrl #(
        .BUS_WIDTH  (8),
        .TIMEOUT_CYC(TO),
        .CNT_W      (8)
    ) dut (
        .D_CLK       (D_CLK),
        .D_RST       (D_RST),
        .SYNC_REQ    (SYNC_REQ),
        .UNSYNC_BUS  (UNSYNC_BUS),
        .ERR_CLR     (ERR_CLR),
`ifdef HS_DATA_PARITY_EN
        .DATA_PAR    (DATA_PAR),
        .PAR_ERR     (PAR_ERR),
`endif
        .ACK         (ACK),
        .SYNC_BUS    (SYNC_BUS),
        .ENABLE_PULSE(ENABLE_PULSE),
        .BUSY        (BUSY),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    always #5 D_CLK = ~D_CLK;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ack, input logic busy,
                           input logic en, input logic err);
        chk1({tag, "_ack"},  ACK,          ack);
        chk1({tag, "_busy"}, BUSY,         busy);
        chk1({tag, "_en"},   ENABLE_PULSE, en);
        chk1({tag, "_err"},  TIMEOUT_ERR,  err);
    endtask

    task automatic step();
        @(posedge D_CLK);
        #1;
    endtask

    task automatic drive_bus(input logic [7:0] d);
        UNSYNC_BUS = d;
`ifdef HS_DATA_PARITY_EN
        DATA_PAR = ^d;
`endif
    endtask

    // Scoreboard: every enable strobe must match the oldest outstanding capture.
    always @(negedge D_CLK) begin
        logic [7:0] e;
        if (ENABLE_PULSE === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got pulse with bus %h want no pulse", SYNC_BUS);
            end else begin
                e = exp_q.pop_front();
                chk8("sb_bus", SYNC_BUS, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{data: 8'hA5, hold: 0, exp_to: 1'b0};
        vecs[1] = '{data: 8'h3C, hold: 1, exp_to: 1'b0};
        vecs[2] = '{data: 8'hC3, hold: 2, exp_to: 1'b0};
        vecs[3] = '{data: 8'h5A, hold: 3, exp_to: 1'b0};
        vecs[4] = '{data: 8'h00, hold: 4, exp_to: 1'b1};
        vecs[5] = '{data: 8'hFF, hold: 6, exp_to: 1'b1};
        vecs[6] = '{data: 8'h81, hold: 1, exp_to: 1'b0};

        // Reset held with REQ high: outputs stay 0, capture two edges after release.
        D_RST    = 1'b1;
        SYNC_REQ = 1'b1;
        ERR_CLR  = 1'b0;
        drive_bus(8'h11);
        for (int c = 0; c < 3; c++) begin
            step();
            chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
            chk8("rst_bus", SYNC_BUS, 8'h00);
        end
        D_RST = 1'b0;
        exp_q.push_back(8'h11);
        step();
        chk_out("rel_capt", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("rel_cap", 1'b1, 1'b1, 1'b1, 1'b0);
        chk8("rel_bus", SYNC_BUS, 8'h11);
        SYNC_REQ = 1'b0;
        step();
        chk_out("rel_done", 1'b0, 1'b0, 1'b0, 1'b0);

        // Table of handshakes; each new REQ is raised right after ACK falls.
        for (int v = 0; v < 7; v++) begin
            drive_bus(vecs[v].data);
            SYNC_REQ = 1'b1;
            ERR_CLR  = 1'b1;
            exp_q.push_back(vecs[v].data);
            step();
            ERR_CLR = 1'b0;
            chk_out("v_capt", 1'b0, 1'b1, 1'b0, 1'b0);
            step();
            chk_out("v_cap", 1'b1, 1'b1, 1'b1, 1'b0);
            chk8("v_bus", SYNC_BUS, vecs[v].data);
            for (int i = 1; i <= vecs[v].hold + 1; i++) begin
                if (i == vecs[v].hold + 1) SYNC_REQ = 1'b0;
                step();
                chk_out("v_hs",
                        vecs[v].exp_to ? (i < TO) : (i <= vecs[v].hold),
                        (i <= vecs[v].hold),
                        1'b0,
                        vecs[v].exp_to && (i >= TO));
                chk8("v_hold_bus", SYNC_BUS, vecs[v].data);
            end
        end

        // One-cycle REQ glitch still completes a full capture.
        drive_bus(8'h96);
        SYNC_REQ = 1'b1;
        ERR_CLR  = 1'b1;
        exp_q.push_back(8'h96);
        step();
        ERR_CLR  = 1'b0;
        SYNC_REQ = 1'b0;
        chk_out("gl_capt", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("gl_cap", 1'b1, 1'b1, 1'b1, 1'b0);
        chk8("gl_bus", SYNC_BUS, 8'h96);
        step();
        chk_out("gl_done", 1'b0, 1'b0, 1'b0, 1'b0);

        // Timeout coinciding with ERR_CLR: set wins; held clear then drops it; no retrigger.
        drive_bus(8'h77);
        SYNC_REQ = 1'b1;
        exp_q.push_back(8'h77);
        step();
        step();
        chk_out("to_cap", 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < TO; i++) begin
            step();
            chk_out("to_hi", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        ERR_CLR = 1'b1;
        step();
        chk_out("to_set", 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        chk_out("to_clr", 1'b0, 1'b1, 1'b0, 1'b0);
        ERR_CLR = 1'b0;
        step();
        chk_out("to_stale", 1'b0, 1'b1, 1'b0, 1'b0);
        chk8("to_bus", SYNC_BUS, 8'h77);
        SYNC_REQ = 1'b0;
        step();
        chk_out("to_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while ACK is high.
        drive_bus(8'hE7);
        SYNC_REQ = 1'b1;
        exp_q.push_back(8'hE7);
        step();
        step();
        step();
        chk_out("mr_hi", 1'b1, 1'b1, 1'b0, 1'b0);
        D_RST = 1'b1;
        step();
        chk_out("mr_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk8("mr_bus", SYNC_BUS, 8'h00);
        D_RST    = 1'b0;
        SYNC_REQ = 1'b0;
        step();
        chk_out("mr_idle", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef HS_DATA_PARITY_EN
        // Bad parity: no strobe, bus held, ACK still raised.
        UNSYNC_BUS = 8'h01;
        DATA_PAR   = 1'b0;
        SYNC_REQ   = 1'b1;
        step();
        chk1("par_pre", PAR_ERR, 1'b0);
        step();
        chk_out("par_cap", 1'b1, 1'b1, 1'b0, 1'b0);
        chk1("par_err", PAR_ERR, 1'b1);
        chk8("par_bus", SYNC_BUS, 8'h00);
        SYNC_REQ = 1'b0;
        step();
        chk_out("par_done", 1'b0, 1'b0, 1'b0, 1'b0);
        chk1("par_clr", PAR_ERR, 1'b0);
`endif

        step();
        chk1("sb_drain", (exp_q.size() == 0), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
